// File: rtl/argmin_seq_16bit.sv
// Sequential arg-min over NUM_GROUPS groups of eight 16-bit distances.
// Uses an external 8-input comparator and keeps a running minimum across groups.
module argmin_seq_16bit #(
    parameter int NUM_GROUPS = 4,
    parameter int IDX_W      = 3 + $clog2(NUM_GROUPS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               grp_valid,
    input  logic [127:0]       grp_data,
    output logic               grp_ready,
    output logic [127:0]       cmp_in,
    input  logic [15:0]        cmp_d,
    input  logic [2:0]         cmp_arg,
    output logic               busy,
    output logic               done,
    output logic [15:0]        win_dist,
    output logic [IDX_W-1:0]   win_idx,
    output logic [1:0]         state_dbg
);

    localparam int GW = IDX_W - 3;
    localparam logic [GW-1:0] LAST_GRP = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [GW-1:0]      grp_cnt_q;
    logic [15:0]        run_dist_q;
    logic [IDX_W-1:0]   run_idx_q;
    logic [127:0]       cmp_in_q;
    logic [15:0]        win_dist_q;
    logic [IDX_W-1:0]   win_idx_q;
    logic               done_q;
    logic               busy_q;
    logic               grp_ready_q;

    // Running best including the group currently on the comparator.
    // Strict compare keeps the earlier group on ties.
    logic               take_d;
    logic [15:0]        best_dist_d;
    logic [IDX_W-1:0]   best_idx_d;

    always_comb begin
        take_d      = (grp_cnt_q == '0) || (cmp_d < run_dist_q);
        best_dist_d = run_dist_q;
        best_idx_d  = run_idx_q;
        if (take_d) begin
            best_dist_d = cmp_d;
            best_idx_d  = {grp_cnt_q, cmp_arg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grp_cnt_q   <= '0;
            run_dist_q  <= '0;
            run_idx_q   <= '0;
            cmp_in_q    <= '0;
            win_dist_q  <= '0;
            win_idx_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            grp_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                grp_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q     <= S_LOAD;
                            grp_cnt_q   <= '0;
                            run_dist_q  <= '0;
                            run_idx_q   <= '0;
                            busy_q      <= 1'b1;
                            grp_ready_q <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (grp_valid) begin
                            cmp_in_q    <= grp_data;
                            state_q     <= S_EVAL;
                            grp_ready_q <= 1'b0;
                        end
                    end
                    S_EVAL: begin
                        run_dist_q <= best_dist_d;
                        run_idx_q  <= best_idx_d;
                        if (grp_cnt_q == LAST_GRP) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            win_dist_q <= best_dist_d;
                            win_idx_q  <= best_idx_d;
                        end else begin
                            grp_cnt_q   <= grp_cnt_q + 1'b1;
                            state_q     <= S_LOAD;
                            grp_ready_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        grp_ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign grp_ready = grp_ready_q;
    assign cmp_in    = cmp_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign win_dist  = win_dist_q;
    assign win_idx   = win_idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_argmin_seq_16bit.sv
// Bench for argmin_seq_16bit: flat-scan reference model, scoreboard on done,
// latency, stall, abort and asynchronous reset scenarios.
module tb_argmin_seq_16bit;

    localparam int NG = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          grp_valid = 1'b0;
    logic [127:0]  grp_data = '0;
    logic          grp_ready;
    logic [127:0]  cmp_in;
    logic [15:0]   cmp_d;
    logic [2:0]    cmp_arg;
    logic          busy;
    logic          done;
    logic [15:0]   win_dist;
    logic [IW-1:0] win_idx;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    logic [127:0]  grp_mem [NG];
    logic [15:0]   exp_dist_q[$];
    logic [IW-1:0] exp_idx_q[$];

    argmin_seq_16bit #(.NUM_GROUPS(NG), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .grp_valid(grp_valid), .grp_data(grp_data), .grp_ready(grp_ready),
        .cmp_in(cmp_in), .cmp_d(cmp_d), .cmp_arg(cmp_arg), .busy(busy),
        .done(done), .win_dist(win_dist), .win_idx(win_idx), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // external comparator: minimum of eight, lowest index on ties
    always_comb begin
        cmp_d   = cmp_in[15:0];
        cmp_arg = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (cmp_in[k*16 +: 16] < cmp_d) begin
                cmp_d   = cmp_in[k*16 +: 16];
                cmp_arg = 3'(k);
            end
        end
    end

    // reference: flat scan over all centroids, first strict minimum wins
    task automatic ref_push();
        logic [15:0]   best;
        logic [IW-1:0] bidx;
        logic [127:0]  row;
        logic [15:0]   v;
        row  = grp_mem[0];
        best = row[15:0];
        bidx = '0;
        for (int k = 1; k < NG * 8; k++) begin
            row = grp_mem[k / 8];
            v   = row[(k % 8) * 16 +: 16];
            if (v < best) begin
                best = v;
                bidx = IW'(k);
            end
        end
        exp_dist_q.push_back(best);
        exp_idx_q.push_back(bidx);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (reset_n && done) begin
            n_done++;
            n_checks++;
            if (exp_dist_q.size() == 0) begin
                $display("FAIL sb_unexpected_done: got done=1 required no done (queue empty)");
            end else begin
                logic [15:0]   ed;
                logic [IW-1:0] ei;
                ed = exp_dist_q.pop_front();
                ei = exp_idx_q.pop_front();
                if (win_dist !== ed || win_idx !== ei)
                    $display("FAIL sb_result: got dist=%h idx=%0d required dist=%h idx=%0d",
                             win_dist, win_idx, ed, ei);
                else
                    n_pass++;
            end
        end
    end

    // driver: one search; stops on done, budget, or on reaching EVAL of stop_grp
    task automatic drive_search(input int stall_grp, input int stall_len, input int stop_grp,
                                input bit start_mid, output int lat, output bit got_done,
                                output bit stall_ok);
        int g;
        int left;
        g = 0;
        left = stall_len;
        lat = 0;
        got_done = 1'b0;
        stall_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (lat < 100) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (stop_grp >= 0 && g == stop_grp + 1 && busy && !grp_ready) break;
            if (grp_ready && g < NG) begin
                if (g == stall_grp && left > 0) begin
                    if (g > 0 && cmp_in !== grp_mem[g-1]) stall_ok = 1'b0;
                    grp_valid = 1'b0;
                    left--;
                end else begin
                    grp_valid = 1'b1;
                    grp_data  = grp_mem[g];
                    g++;
                end
            end else begin
                grp_valid = 1'b1;
                grp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            start = (start_mid && lat == 3);
            @(negedge clk);
            lat++;
        end
        grp_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int g = 0; g < NG; g++)
            for (int k = 0; k < 8; k++)
                grp_mem[g][k*16 +: 16] = 16'($urandom_range(hi, lo));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({grp_ready, busy, done, cmp_in, win_dist, win_idx, state_dbg} !== '0)
            $display("FAIL reset_held: got ready=%b busy=%b done=%b dist=%h idx=%0d st=%0d required all 0",
                     grp_ready, busy, done, win_dist, win_idx, state_dbg);
        else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || state_dbg !== 2'd0)
            $display("FAIL reset_idle_after_release: got busy=%b st=%0d required 0/0", busy, state_dbg);
        else n_pass++;
    endtask

    task automatic test_single_min();
        int lat; bit got; bit sok;
        fill_random(16'h0100, 16'hFFFF);
        grp_mem[2][5*16 +: 16] = 16'h0010;
        ref_push();
        drive_search(-1, 0, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || lat != 9) $display("FAIL single_latency: got done=%b lat=%0d required done=1 lat=9", got, lat);
        else n_pass++;
        n_checks++;
        if (win_idx !== 5'd21 || win_dist !== 16'h0010)
            $display("FAIL single_result: got idx=%0d dist=%h required idx=21 dist=0010", win_idx, win_dist);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_done_pulse: got done=%b busy=%b required 0/0", done, busy);
        else n_pass++;
    endtask

    task automatic test_tie();
        int lat; bit got; bit sok;
        fill_random(16'h0101, 16'hFFFF);
        grp_mem[0][3*16 +: 16] = 16'h0100;
        grp_mem[3][1*16 +: 16] = 16'h0100;
        ref_push();
        drive_search(-1, 0, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || win_idx !== 5'd3 || win_dist !== 16'h0100)
            $display("FAIL tie_result: got done=%b idx=%0d dist=%h required idx=3 dist=0100", got, win_idx, win_dist);
        else n_pass++;
    endtask

    task automatic test_stall();
        int lat; bit got; bit sok;
        fill_random(16'h0100, 16'hFFFF);
        grp_mem[2][5*16 +: 16] = 16'h0010;
        ref_push();
        drive_search(1, 3, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || lat != 12) $display("FAIL stall_latency: got done=%b lat=%0d required done=1 lat=12", got, lat);
        else n_pass++;
        n_checks++;
        if (!sok) $display("FAIL stall_cmp_in_hold: got cmp_in changed required held at group 0");
        else n_pass++;
        n_checks++;
        if (win_idx !== 5'd21 || win_dist !== 16'h0010)
            $display("FAIL stall_result: got idx=%0d dist=%h required idx=21 dist=0010", win_idx, win_dist);
        else n_pass++;
    endtask

    task automatic test_all_ff();
        int lat; bit got; bit sok;
        for (int g = 0; g < NG; g++) grp_mem[g] = {128{1'b1}};
        ref_push();
        drive_search(-1, 0, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || win_idx !== 5'd0 || win_dist !== 16'hFFFF)
            $display("FAIL all_ff_result: got done=%b idx=%0d dist=%h required idx=0 dist=ffff", got, win_idx, win_dist);
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat; bit got; bit sok; int done_before;
        fill_random(16'h0100, 16'hFFFF);
        grp_mem[0][7*16 +: 16] = 16'h0042;
        ref_push();
        drive_search(-1, 0, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || win_idx !== 5'd7 || win_dist !== 16'h0042)
            $display("FAIL abort_prior_result: got idx=%0d dist=%h required idx=7 dist=0042", win_idx, win_dist);
        else n_pass++;
        fill_random(16'h0100, 16'hFFFF);
        grp_mem[1][0 +: 16] = 16'h0001;
        drive_search(-1, 0, 2, 1'b1, lat, got, sok);
        n_checks++;
        if (got || lat != 6 || state_dbg !== 2'd2)
            $display("FAIL abort_reach_eval2: got done=%b lat=%0d st=%0d required done=0 lat=6 st=2 (start mid-run ignored)",
                     got, lat, state_dbg);
        else n_pass++;
        done_before = n_done;
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || grp_ready !== 1'b0 || state_dbg !== 2'd0)
            $display("FAIL abort_to_idle: got busy=%b ready=%b st=%0d required 0/0/0", busy, grp_ready, state_dbg);
        else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if (n_done != done_before || win_idx !== 5'd7 || win_dist !== 16'h0042 || busy !== 1'b0)
            $display("FAIL abort_retain: got dones=%0d idx=%0d dist=%h busy=%b required dones=%0d idx=7 dist=0042 busy=0",
                     n_done - done_before, win_idx, win_dist, busy, 0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; bit got; bit sok;
        fill_random(16'h0100, 16'h0FFF);
        drive_search(-1, 0, 1, 1'b0, lat, got, sok);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({grp_ready, busy, done, cmp_in, win_dist, win_idx, state_dbg} !== '0)
            $display("FAIL reset_async_mid: got ready=%b busy=%b dist=%h idx=%0d st=%0d cmp_in=%h required all 0",
                     grp_ready, busy, win_dist, win_idx, state_dbg, cmp_in);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || win_dist !== 16'h0) $display("FAIL reset_no_autostart: got busy=%b dist=%h required 0/0", busy, win_dist);
        else n_pass++;
        fill_random(0, 16'hFFFF);
        ref_push();
        drive_search(-1, 0, -1, 1'b0, lat, got, sok);
        n_checks++;
        if (!got || lat != 9) $display("FAIL reset_clean_search: got done=%b lat=%0d required done=1 lat=9", got, lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; bit got; bit sok; int sg; int sl;
        for (int r = 0; r < 6; r++) begin
            fill_random(0, 7);
            sg = $urandom_range(3, 0);
            sl = $urandom_range(2, 0);
            ref_push();
            drive_search(sg, sl, -1, 1'b0, lat, got, sok);
            n_checks++;
            if (!got || lat != 9 + sl || !sok)
                $display("FAIL b2b_run%0d: got done=%b lat=%0d hold=%b required done=1 lat=%0d hold=1",
                         r, got, lat, sok, 9 + sl);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_min();
        test_tie();
        test_stall();
        test_all_ff();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_dist_q.size() != 0)
            $display("FAIL sb_drain: got %0d pending results required 0", exp_dist_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
